// File: rtl/sram_fifo_pkg.sv
// Shared widths and pointer helpers for the SRAM-backed valid/ready FIFO.
package sram_fifo_pkg;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 2);
  endfunction

  // Wraps at depth-1 so non-power-of-two depths use every RAM word.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sramRW.sv
// Generic two-port synchronous RAM: one write port, one read port with
// a resettable registered output (or a combinational read when FALL_THROUGH=1).
module sramRW #(
  parameter int SIZE         = 16,
  parameter int DATA_WIDTH   = 4,
  parameter int FALL_THROUGH = 0,
  localparam int ADDR_W      = (SIZE < 2) ? 1 : $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  r,
  input  logic [ADDR_W-1:0]     rAddr,
  output logic [DATA_WIDTH-1:0] rData,
  input  logic                  w,
  input  logic [ADDR_W-1:0]     wAddr,
  input  logic [DATA_WIDTH-1:0] wData
);

  logic [DATA_WIDTH-1:0] r_mem [SIZE];

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (en && w) begin
      r_mem[wAddr] <= wData;
    end
  end

  generate
    if (FALL_THROUGH != 0) begin : g_comb_read
      assign rData = r_mem[rAddr];
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] r_data;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data <= '0;
        end else if (en && r) begin
          r_data <= r_mem[rAddr];
        end
      end
      assign rData = r_data;
    end
  endgenerate

endmodule

// File: rtl/sram_fifo.sv
// Valid/ready FIFO control around sramRW; the RAM read register is the
// FIFO output slot, giving DEPTH+1 words of capacity.
module sram_fifo
  import sram_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 4,
  localparam int CNT_W     = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_ram_cnt;
  logic             r_out_valid;

  logic             w_push;
  logic             w_rd;
  logic [PTR_W-1:0] w_wptr_inc;
  logic [PTR_W-1:0] w_rptr_inc;

  assign in_ready   = (r_ram_cnt != CNT_W'(DEPTH)) && !clr;
  assign w_push     = in_valid && in_ready;
  // Refill the output slot whenever it is empty or being drained this cycle.
  assign w_rd       = (r_ram_cnt != '0) && (!r_out_valid || out_ready) && !clr;
  assign w_wptr_inc = PTR_W'(ptr_inc(32'(r_wptr), DEPTH));
  assign w_rptr_inc = PTR_W'(ptr_inc(32'(r_rptr), DEPTH));

  assign out_valid  = r_out_valid;
  assign count      = r_ram_cnt + CNT_W'(r_out_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_ram_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else if (clr) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_ram_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= w_wptr_inc;
      end
      if (w_rd) begin
        r_rptr <= w_rptr_inc;
      end
      case ({w_push, w_rd})
        2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
        2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
        default: r_ram_cnt <= r_ram_cnt;
      endcase
      if (w_rd) begin
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  sramRW #(
    .SIZE         (DEPTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .FALL_THROUGH (0)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .r     (w_rd),
    .rAddr (r_rptr),
    .rData (out_data),
    .w     (w_push),
    .wAddr (r_wptr),
    .wData (in_data)
  );

endmodule

// File: tb/tb_sram_fifo.sv
// Scoreboard bench for sram_fifo: stimulus pushes expected words, a negedge
// monitor pops and compares them and tracks count and stall stability.
module tb_sram_fifo;

  localparam int DEPTH = 5;
  localparam int DW    = 4;
  localparam int CW    = $clog2(DEPTH + 2);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  sram_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sample the handshake before the edge that acts on it.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      check("count_vs_model", int'(count), exp_q.size());
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(prev_data));
      end
      if (!clr && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_underflow: got data %0d, required no output", out_data);
        end else begin
          check("pop_data", int'(out_data), int'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (clr) exp_q.delete();
      prev_stall <= out_valid && !out_ready && !clr;
      prev_data  <= out_data;
    end
  end

  initial begin
    // Asynchronous reset state
    #1 rst = 1'b1;
    #3;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_count", int'(count), 0);
    check("rst_out_data", int'(out_data), 0);
    #18 rst = 1'b0;
    step();
    @(negedge clk);
    check("idle_out_valid", int'(out_valid), 0);
    check("idle_in_ready", int'(in_ready), 1);
    check("idle_out_data", int'(out_data), 0);
    step();

    // Two-cycle latency from in_valid to out_valid
    in_valid = 1'b1;
    in_data  = 4'hA;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_valid_t0", int'(out_valid), 0);
    @(negedge clk);
    check("lat_valid_t1", int'(out_valid), 1);
    check("lat_data_t1", int'(out_data), 'hA);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (2) step();

    // Fill to DEPTH+1 words; the next offer must be refused
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i + 1);
      @(negedge clk);
      check("fill_in_ready", int'(in_ready), (i < DEPTH + 1) ? 1 : 0);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("full_count", int'(count), DEPTH + 1);
    check("full_in_ready", int'(in_ready), 0);
    check("full_head", int'(out_data), 1);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_in_ready_before_rd", int'(in_ready), 0);
    step();
    @(negedge clk);
    check("drain_in_ready_after_rd", int'(in_ready), 1);
    repeat (8) step();
    out_ready = 1'b0;
    @(negedge clk);
    check("drain_out_valid", int'(out_valid), 0);
    check("drain_count", int'(count), 0);
    step();

    // Continuous stream across pointer wrap, one word per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      @(negedge clk);
      check("stream_in_ready", int'(in_ready), 1);
      if (i >= 2) check("stream_out_valid", int'(out_valid), 1);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check("stream_end_valid", int'(out_valid), 0);
    step();

    // Synchronous flush with a push offered in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(3 + i);
      step();
    end
    in_data = 4'hE;
    clr     = 1'b1;
    @(negedge clk);
    check("clr_count_before", int'(count), 4);
    check("clr_in_ready", int'(in_ready), 0);
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_count_after", int'(count), 0);
    check("clr_out_valid", int'(out_valid), 0);
    step();
    in_valid = 1'b1;
    in_data  = 4'h9;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("clr_post_drain", int'(count), 0);
    step();

    // Random traffic alternating between fill-heavy and drain-heavy phases
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int phase;
      phase     = (cyc / 500) % 2;
      in_valid  = $urandom_range(0, 99) < ((phase == 0) ? 75 : 30);
      out_ready = $urandom_range(0, 99) < ((phase == 0) ? 30 : 75);
      in_data   = DW'($urandom_range(0, 15));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    check("rand_empty_count", int'(count), 0);
    check("rand_empty_valid", int'(out_valid), 0);
    step();

    // Asynchronous reset mid-burst
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      step();
    end
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_count", int'(count), 0);
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_out_data", int'(out_data), 0);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'hB;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("arst_lat_t0", int'(out_valid), 0);
    @(negedge clk);
    check("arst_lat_t1", int'(out_valid), 1);
    check("arst_lat_data", int'(out_data), 'hB);
    repeat (3) step();
    @(negedge clk);
    check("final_count", int'(count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
